// File: rtl/telem_pkg.sv
// Shared definitions for the UART telemetry framer.
//   state_t     : framer FSM states
//   DEF_HDR*/DEF_TRL* : default header ("a","b") and trailer (CR, LF) bytes
//   pos_t       : widest sequence-position field (NUM_BYTES=32 with checksum)
//   pos_width() : position-counter width for a given payload size
package telem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GUARD,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [7:0] DEF_HDR0 = 8'h61;
  localparam logic [7:0] DEF_HDR1 = 8'h62;
  localparam logic [7:0] DEF_TRL0 = 8'h0D;
  localparam logic [7:0] DEF_TRL1 = 8'h0A;

  localparam int unsigned POS_W_MAX = 6;
  typedef logic [POS_W_MAX-1:0] pos_t;

  function automatic int unsigned pos_width(input int unsigned num_bytes);
    return $clog2(num_bytes + 5);
  endfunction

endpackage

// File: rtl/telem_period_tick.sv
// Free-running frame-period counter.
//   clk, rst : system clock, synchronous active-high reset
//   tick_o   : one-cycle pulse when the counter reaches PERIOD_CYC-1 (then wraps to 0)
// PERIOD_CYC = 0 disables the tick entirely (trigger-only operation).
module telem_period_tick #(
  parameter int unsigned PERIOD_CYC = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam bit          EN   = (PERIOD_CYC != 0);
  localparam int unsigned CW   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int unsigned LAST = EN ? (PERIOD_CYC - 1) : 0;

  logic [CW-1:0] cnt;
  logic          at_last;

  assign at_last = (cnt == CW'(LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (EN) begin
      if (at_last) cnt <= '0;
      else         cnt <= cnt + 1'b1;
    end
  end

  assign tick_o = EN && at_last;

endmodule

// File: rtl/uart_telemetry_framer.sv
// Periodic / triggered telemetry frame generator for a byte-wide UART TX.
// Snapshots the payload when a frame is requested, then sends
//   HDR0 HDR1 payload[0..NUM_BYTES-1] [checksum] TRL0 TRL1
// pacing each byte on the transmitter's busy flag.
// Optional build macro: TELEM_CHECKSUM_EN inserts a two's-complement
// checksum byte (header + payload + checksum sums to 8'h00).
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   payload_i     : payload, byte k at [8k+7:8k], byte 0 sent first
//   trig_i        : one-cycle request for an immediate frame
//   tx_busy_i     : UART transmitter busy
//   tx_start_o    : one-cycle load strobe for the UART
//   tx_data_o     : byte to send, held until the next tx_start_o
//   frame_busy_o  : frame in progress
//   frame_done_o  : one-cycle pulse after the last trailer byte completes
//   overrun_o     : sticky, a request arrived while a frame was in progress
module uart_telemetry_framer
  import telem_pkg::*;
#(
  parameter int unsigned NUM_BYTES  = 5,
  parameter int unsigned PERIOD_CYC = 10_000_000,
  parameter logic [7:0]  HDR0       = DEF_HDR0,
  parameter logic [7:0]  HDR1       = DEF_HDR1,
  parameter logic [7:0]  TRL0       = DEF_TRL0,
  parameter logic [7:0]  TRL1       = DEF_TRL1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*NUM_BYTES-1:0] payload_i,
  input  logic                   trig_i,
  input  logic                   tx_busy_i,
  output logic                   tx_start_o,
  output logic [7:0]             tx_data_o,
  output logic                   frame_busy_o,
  output logic                   frame_done_o,
  output logic                   overrun_o
);

  localparam int unsigned POS_W = pos_width(NUM_BYTES);
`ifdef TELEM_CHECKSUM_EN
  localparam int unsigned CK_POS  = NUM_BYTES + 2;
  localparam int unsigned TRL_POS = NUM_BYTES + 3;
`else
  localparam int unsigned TRL_POS = NUM_BYTES + 2;
`endif
  localparam int unsigned LAST_POS = TRL_POS + 1;

  state_t                 state, state_next;
  logic [POS_W-1:0]       pos;
  logic [8*NUM_BYTES-1:0] snap;
  logic [7:0]             seq_byte;
  logic                   tick, req, accept, last_pos;

`ifdef TELEM_CHECKSUM_EN
  logic [7:0] ck_sum;
`endif

  telem_period_tick #(.PERIOD_CYC(PERIOD_CYC)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .tick_o(tick)
  );

  // A tick and a trigger in the same cycle collapse into one request.
  assign req      = tick | trig_i;
  assign accept   = req && (state == ST_IDLE);
  assign last_pos = (pos == POS_W'(LAST_POS));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (req) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_SEND;
      ST_SEND:  if (!tx_busy_i) state_next = ST_GUARD;
      // TX raises busy one cycle after start, so busy is not trusted here.
      ST_GUARD: state_next = ST_WAIT;
      ST_WAIT:  if (!tx_busy_i) state_next = last_pos ? ST_DONE : ST_LOAD;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    tx_start_o   = (state == ST_SEND) && !tx_busy_i;
    frame_busy_o = state inside {ST_LOAD, ST_SEND, ST_GUARD, ST_WAIT};
    frame_done_o = (state == ST_DONE);
  end

  // Byte selected by the current sequence position
  always_comb begin
    seq_byte = TRL1;
    if (pos == '0)                seq_byte = HDR0;
    if (pos == POS_W'(1))         seq_byte = HDR1;
    if (pos == POS_W'(TRL_POS))   seq_byte = TRL0;
`ifdef TELEM_CHECKSUM_EN
    if (pos == POS_W'(CK_POS))    seq_byte = 8'h00 - ck_sum;
`endif
    for (int unsigned k = 0; k < NUM_BYTES; k++) begin
      if (pos == POS_W'(k + 2)) seq_byte = snap[8*k +: 8];
    end
  end

  // Snapshot, position, data register, overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      snap      <= '0;
      pos       <= '0;
      tx_data_o <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (req && (state != ST_IDLE)) overrun_o <= 1'b1;
      if (accept) begin
        snap <= payload_i;
        pos  <= '0;
      end
      if (state == ST_LOAD) tx_data_o <= seq_byte;
      if ((state == ST_WAIT) && !tx_busy_i && !last_pos) pos <= pos + 1'b1;
    end
  end

`ifdef TELEM_CHECKSUM_EN
  // Running sum: seeded with the header, each payload byte added as it is loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      ck_sum <= '0;
    end else if (accept) begin
      ck_sum <= HDR0 + HDR1;
    end else if ((state == ST_LOAD) && (pos >= POS_W'(2)) && (pos < POS_W'(CK_POS))) begin
      ck_sum <= ck_sum + seq_byte;
    end
  end
`endif

endmodule
